fetch_pc_gen: RTL and testbench
===============================

FETCH_PC_GEN -- requirements
Module: fetch_pc_gen

Interface
REQ-001 Parameter RESET_PC, default 32'h8000_0000, first fetch address after reset.
REQ-002 Parameter FQ_DEPTH, default 4 (power of 2), prediction-queue entries.
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 pc_out  output  32  current fetch PC; drives BTB lookup PC and instruction memory address.
REQ-006 btb_hit  input  1  combinational BTB hit for pc_out.
REQ-007 btb_target  input  32  BTB target for pc_out; valid only when btb_hit.
REQ-008 fetch_valid  output  1  pc_out is being offered to decode this cycle.
REQ-009 dec_ready  input  1  decode accepts the offered fetch.
REQ-010 redirect_valid  input  1  EX-stage mispredict/jump redirect.
REQ-011 redirect_pc  input  32  redirect destination.
REQ-012 pred_valid  output  1  prediction queue non-empty.
REQ-013 pred_pc  output  32  head entry fetch PC.
REQ-014 pred_taken  output  1  head entry BTB-predicted taken.
REQ-015 pred_next  output  32  head entry predicted next PC.
REQ-016 pred_deq  input  1  EX consumes head entry.

Function
REQ-017 FSM states: BOOT, RUN, FLUSH; BOOT and FLUSH each last exactly one cycle, then go to RUN.
REQ-018 fetch_valid = (state==RUN) && !queue_full; 0 in BOOT and FLUSH.
REQ-019 fire = fetch_valid && dec_ready && !redirect_valid.
REQ-020 next_pred = btb_hit ? {btb_target[31:2],2'b00} : pc_out+4, 32-bit modulo (wraps at 32'hFFFF_FFFC -> 0).
REQ-021 On fire: pc_out <= next_pred; enqueue {pc_out, btb_hit, next_pred} at tail.
REQ-022 fetch_valid && !dec_ready && !redirect_valid: pc_out held, no enqueue.
REQ-023 redirect_valid (any state): pc_out <= {redirect_pc[31:2],2'b00}, queue emptied, state <= FLUSH next cycle; any same-cycle fire, enqueue or pred_deq discarded.
REQ-024 Redirect in FLUSH cycle: accepted again, FLUSH extended by one cycle.
REQ-025 pred_deq with queue empty: ignored, no pointer change.
REQ-026 Simultaneous enqueue and dequeue: both performed, occupancy unchanged.
REQ-027 Queue full: fetch_valid=0 until a pred_deq frees an entry; fetch_valid rises the cycle after dequeue.
REQ-028 Head outputs combinational from head entry; pred_pc/pred_taken/pred_next are 0 when pred_valid=0.
REQ-029 Pointers are log2(FQ_DEPTH) bits wrapping; occupancy counter log2(FQ_DEPTH)+1 bits, range 0..FQ_DEPTH.

Reset
REQ-030 rst high: pc_out=RESET_PC, state=BOOT, queue empty, pointers/count 0, fetch_valid=0, pred_valid=0.
REQ-031 rst dominates redirect_valid, dec_ready and pred_deq in the same cycle.
REQ-032 rst asserted mid-operation discards all queued predictions; first RUN cycle follows one BOOT cycle after rst deasserts.

Structure
REQ-033 Shared package holds RESET_PC default, instruction-step constant (4) and the prediction-entry record layout (pc 32, taken 1, next 32 = 65 bits).
REQ-034 Prediction queue is one sub-module, pred_fifo (parameterised depth/width, flush input), instantiated once.
REQ-035 No combinational path from pred_deq to fetch_valid.

Verification
REQ-036 Reset, dec_ready=1, btb_hit=0 -> BOOT 1 cycle, then pc_out 8000_0000, 8000_0004, 8000_0008 on successive cycles, each enqueued.
REQ-037 pc_out=8000_0010, btb_hit=1, btb_target=8000_0103 -> next pc_out 8000_0100; queue entry {8000_0010,1,8000_0100}.
REQ-038 dec_ready=1, pred_deq=0 for 4 fires -> pred_valid=1, fetch_valid=0, pc_out frozen; one pred_deq -> fetch_valid=1 next cycle.
REQ-039 redirect_valid=1, redirect_pc=8000_2002 during fire with 3 entries queued -> queue empty, fetch_valid=0 one cycle, then pc_out 8000_2000.
REQ-040 pc_out=FFFF_FFFC, btb_hit=0, fire -> pc_out 0000_0000.
REQ-041 rst mid-stream with 2 entries queued and redirect_valid=1 -> pc_out=8000_0000, pred_valid=0, BOOT next.

Source files
------------

// File: rtl/fetch_pc_gen_pkg.sv
// Shared types and constants for the fetch PC generator and its prediction queue.
package fetch_pc_gen_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
  localparam logic [31:0] INSN_STEP        = 32'd4;

  // One prediction record handed from fetch to EX.
  typedef struct packed {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] next;
  } pred_entry_t;

  localparam int PRED_W = $bits(pred_entry_t);

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_RUN,
    ST_FLUSH
  } fetch_state_e;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_pc_gen_pred_fifo.sv
// Prediction queue: power-of-2 depth FIFO with flush and a combinational head.
module pred_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 65
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             enq,
  input  logic [WIDTH-1:0] enq_data,
  input  logic             deq,
  output logic [WIDTH-1:0] head_data,
  output logic             empty,
  output logic             full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_enq, do_deq;

  assign empty  = (count == '0);
  assign full   = (count == (AW+1)'(DEPTH));
  // Flush wins over anything requested in the same cycle.
  assign do_enq = enq && !full  && !flush;
  assign do_deq = deq && !empty && !flush;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_enq) wr_ptr <= wr_ptr + AW'(1);
      if (do_deq) rd_ptr <= rd_ptr + AW'(1);
      case ({do_enq, do_deq})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_enq) mem[wr_ptr] <= enq_data;
  end

  assign head_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/fetch_pc_gen.sv
// Fetch PC generator: BTB-steered next-PC selection, redirect handling, prediction queue to EX.
module fetch_pc_gen
  import fetch_pc_gen_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          FQ_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] pc_out,
  input  logic        btb_hit,
  input  logic [31:0] btb_target,
  output logic        fetch_valid,
  input  logic        dec_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        pred_valid,
  output logic [31:0] pred_pc,
  output logic        pred_taken,
  output logic [31:0] pred_next,
  input  logic        pred_deq
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  next_pred;
  logic         fire;
  logic         fifo_empty, fifo_full;
  pred_entry_t  enq_entry, head_entry;

  // fifo_full comes straight from the occupancy register, so pred_deq never
  // reaches fetch_valid combinationally.
  assign fetch_valid = (state_q == ST_RUN) && !fifo_full;
  assign fire        = fetch_valid && dec_ready && !redirect_valid;
  assign next_pred   = btb_hit ? word_align(btb_target) : pc_q + INSN_STEP;
  assign pc_out      = pc_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if (redirect_valid) begin
      state_d = ST_FLUSH;
      pc_d    = word_align(redirect_pc);
    end else begin
      if (state_q != ST_RUN) state_d = ST_RUN;
      if (fire)              pc_d    = next_pred;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign enq_entry = '{pc: pc_q, taken: btb_hit, next: next_pred};

  pred_fifo #(
    .DEPTH (FQ_DEPTH),
    .WIDTH (PRED_W)
  ) u_pred_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .enq       (fire),
    .enq_data  (enq_entry),
    .deq       (pred_deq),
    .head_data (head_entry),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign pred_valid = !fifo_empty;
  assign pred_pc    = head_entry.pc;
  assign pred_taken = head_entry.taken;
  assign pred_next  = head_entry.next;

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Directed table-driven bench for fetch_pc_gen plus a few hand-written multi-cycle sequences.
module tb_fetch_pc_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_out;
  logic        btb_hit;
  logic [31:0] btb_target;
  logic        fetch_valid;
  logic        dec_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        pred_valid;
  logic [31:0] pred_pc;
  logic        pred_taken;
  logic [31:0] pred_next;
  logic        pred_deq;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fetch_pc_gen dut (
    .clk            (clk),
    .rst            (rst),
    .pc_out         (pc_out),
    .btb_hit        (btb_hit),
    .btb_target     (btb_target),
    .fetch_valid    (fetch_valid),
    .dec_ready      (dec_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .pred_valid     (pred_valid),
    .pred_pc        (pred_pc),
    .pred_taken     (pred_taken),
    .pred_next      (pred_next),
    .pred_deq       (pred_deq)
  );

  // Inputs applied for one cycle, and the outputs expected in that same cycle
  // (all outputs depend only on registered state).
  typedef struct {
    logic        rst, rdy, hit;
    logic [31:0] tgt;
    logic        rv;
    logic [31:0] rpc;
    logic        deq;
    logic [31:0] e_pc;
    logic        e_fv, e_pv;
    logic [31:0] e_ppc;
    logic        e_ptk;
    logic [31:0] e_pnx;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic rdy, input logic hit, input logic [31:0] tgt,
                     input logic rv, input logic [31:0] rpc, input logic deq,
                     input logic [31:0] e_pc, input logic e_fv, input logic e_pv,
                     input logic [31:0] e_ppc, input logic e_ptk, input logic [31:0] e_pnx);
    vec_t v;
    v.rst = r; v.rdy = rdy; v.hit = hit; v.tgt = tgt; v.rv = rv; v.rpc = rpc; v.deq = deq;
    v.e_pc = e_pc; v.e_fv = e_fv; v.e_pv = e_pv; v.e_ppc = e_ppc; v.e_ptk = e_ptk; v.e_pnx = e_pnx;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic rdy, input logic hit, input logic [31:0] tgt,
                       input logic rv, input logic [31:0] rpc, input logic deq);
    @(negedge clk);
    rst = r; dec_ready = rdy; btb_hit = hit; btb_target = tgt;
    redirect_valid = rv; redirect_pc = rpc; pred_deq = deq;
    #1;
  endtask

  initial begin
    rst = 1'b1; dec_ready = 1'b0; btb_hit = 1'b0; btb_target = '0;
    redirect_valid = 1'b0; redirect_pc = '0; pred_deq = 1'b0;

    //   rst rdy hit tgt           rv rpc           deq | pc            fv pv ppc           tk pnx
    add(1, 1, 0, 32'h0,          0, 32'h0,          0,  32'h8000_0000, 0, 0, 32'h0,          0, 32'h0);          // reset state
    add(0, 1, 0, 32'h0,          0, 32'h0,          0,  32'h8000_0000, 0, 0, 32'h0,          0, 32'h0);          // BOOT
    add(0, 1, 0, 32'h0,          0, 32'h0,          0,  32'h8000_0000, 1, 0, 32'h0,          0, 32'h0);
    add(0, 1, 0, 32'h0,          0, 32'h0,          0,  32'h8000_0004, 1, 1, 32'h8000_0000, 0, 32'h8000_0004);
    add(0, 1, 0, 32'h0,          0, 32'h0,          0,  32'h8000_0008, 1, 1, 32'h8000_0000, 0, 32'h8000_0004);
    add(0, 1, 0, 32'h0,          0, 32'h0,          0,  32'h8000_000C, 1, 1, 32'h8000_0000, 0, 32'h8000_0004); // 4th fire fills
    add(0, 1, 1, 32'h8000_0103, 0, 32'h0,          0,  32'h8000_0010, 0, 1, 32'h8000_0000, 0, 32'h8000_0004); // full
    add(0, 1, 1, 32'h8000_0103, 0, 32'h0,          1,  32'h8000_0010, 0, 1, 32'h8000_0000, 0, 32'h8000_0004); // deq
    add(0, 1, 1, 32'h8000_0103, 0, 32'h0,          0,  32'h8000_0010, 1, 1, 32'h8000_0004, 0, 32'h8000_0008); // BTB fire
    add(0, 1, 0, 32'h0,          0, 32'h0,          1,  32'h8000_0100, 0, 1, 32'h8000_0004, 0, 32'h8000_0008);
    add(0, 1, 0, 32'h0,          0, 32'h0,          1,  32'h8000_0100, 1, 1, 32'h8000_0008, 0, 32'h8000_000C); // enq+deq
    add(0, 0, 0, 32'h0,          0, 32'h0,          1,  32'h8000_0104, 1, 1, 32'h8000_000C, 0, 32'h8000_0010); // stall
    add(0, 0, 0, 32'h0,          0, 32'h0,          1,  32'h8000_0104, 1, 1, 32'h8000_0010, 1, 32'h8000_0100); // BTB entry
    add(0, 1, 0, 32'h0,          0, 32'h0,          0,  32'h8000_0104, 1, 1, 32'h8000_0100, 0, 32'h8000_0104);
    add(0, 1, 0, 32'h0,          0, 32'h0,          0,  32'h8000_0108, 1, 1, 32'h8000_0100, 0, 32'h8000_0104);
    add(0, 1, 1, 32'h1234_5678, 1, 32'h8000_2002, 1,  32'h8000_010C, 1, 1, 32'h8000_0100, 0, 32'h8000_0104); // redirect, 3 queued
    add(0, 1, 0, 32'h0,          0, 32'h0,          0,  32'h8000_2000, 0, 0, 32'h0,          0, 32'h0);          // FLUSH
    add(0, 1, 0, 32'h0,          1, 32'h8000_3000, 0,  32'h8000_2000, 1, 0, 32'h0,          0, 32'h0);
    add(0, 1, 0, 32'h0,          1, 32'hFFFF_FFFF, 0,  32'h8000_3000, 0, 0, 32'h0,          0, 32'h0);          // redirect in FLUSH
    add(0, 1, 0, 32'h0,          0, 32'h0,          0,  32'hFFFF_FFFC, 0, 0, 32'h0,          0, 32'h0);          // extended FLUSH
    add(0, 1, 0, 32'h0,          0, 32'h0,          0,  32'hFFFF_FFFC, 1, 0, 32'h0,          0, 32'h0);          // wrap fire
    add(0, 1, 0, 32'h0,          0, 32'h0,          0,  32'h0000_0000, 1, 1, 32'hFFFF_FFFC, 0, 32'h0000_0000);
    add(1, 1, 0, 32'h0,          1, 32'h8000_5000, 1,  32'h0000_0004, 1, 1, 32'hFFFF_FFFC, 0, 32'h0000_0000); // rst vs redirect
    add(0, 1, 0, 32'h0,          0, 32'h0,          1,  32'h8000_0000, 0, 0, 32'h0,          0, 32'h0);          // BOOT, deq empty
    add(0, 0, 0, 32'h0,          0, 32'h0,          1,  32'h8000_0000, 1, 0, 32'h0,          0, 32'h0);
    add(0, 1, 0, 32'h0,          0, 32'h0,          0,  32'h8000_0000, 1, 0, 32'h0,          0, 32'h0);
    add(0, 0, 0, 32'h0,          0, 32'h0,          0,  32'h8000_0004, 1, 1, 32'h8000_0000, 0, 32'h8000_0004);

    repeat (2) @(posedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      vec_t v;
      v = vecs[i];
      drive(v.rst, v.rdy, v.hit, v.tgt, v.rv, v.rpc, v.deq);
      chk($sformatf("v%0d pc_out", i),      pc_out,             v.e_pc);
      chk($sformatf("v%0d fetch_valid", i), 32'(fetch_valid),   32'(v.e_fv));
      chk($sformatf("v%0d pred_valid", i),  32'(pred_valid),    32'(v.e_pv));
      chk($sformatf("v%0d pred_pc", i),     pred_pc,            v.e_ppc);
      chk($sformatf("v%0d pred_taken", i),  32'(pred_taken),    32'(v.e_ptk));
      chk($sformatf("v%0d pred_next", i),   pred_next,          v.e_pnx);
    end

    // Reset-to-first-fetch latency: exactly one BOOT cycle.
    begin
      int lat;
      drive(1, 1, 0, 32'h0, 0, 32'h0, 0);
      lat = 0;
      drive(0, 1, 1, 32'h8000_0403, 0, 32'h0, 0);
      while (!fetch_valid && lat < 8) begin
        lat++;
        drive(0, 1, 1, 32'h8000_0403, 0, 32'h0, 0);
      end
      chk("boot latency", 32'(lat), 32'd1);
    end

    // Hit every cycle with a misaligned target: 4 fires fill the queue, then fetch stalls.
    chk("seq pc0", pc_out, 32'h8000_0000);
    drive(0, 1, 1, 32'h8000_0403, 0, 32'h0, 0);
    chk("seq pc1", pc_out, 32'h8000_0400);
    drive(0, 1, 1, 32'h8000_0403, 0, 32'h0, 0);
    drive(0, 1, 1, 32'h8000_0403, 0, 32'h0, 0);
    chk("seq head taken", 32'(pred_taken), 32'd1);
    chk("seq head next", pred_next, 32'h8000_0400);
    repeat (3) begin
      drive(0, 1, 1, 32'h8000_0403, 0, 32'h0, 0);
      chk("seq full stall", 32'(fetch_valid), 32'd0);
    end
    chk("seq frozen pc", pc_out, 32'h8000_0400);
    // Dequeue while full: fetch_valid must stay low this cycle and rise the next.
    drive(0, 1, 1, 32'h8000_0403, 0, 32'h0, 1);
    chk("seq deq same cycle", 32'(fetch_valid), 32'd0);
    drive(0, 0, 0, 32'h0, 0, 32'h0, 0);
    chk("seq deq next cycle", 32'(fetch_valid), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
